// File: rtl/s2p_rx_controller.sv
// Serial-to-parallel receiver: start bit, LSB-first data, optional parity, stop.
// Optional parity stage is built when S2P_PARITY_EN is defined.
module s2p_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int IDLE_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 a,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] out_p,
    output logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSMIT = 2'd1,
`ifdef S2P_PARITY_EN
        PARITY   = 2'd2,
`endif
        STOP     = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 rdy_q, rdy_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 prev_a_q;
    logic                 frame_ok;
    logic                 start_ok;
    logic                 last_bit;
`ifdef S2P_PARITY_EN
    logic                 pe_q, pe_d;
`endif

    assign start_ok = (IDLE_CHECK == 0) || prev_a_q;
    assign last_bit = (cnt_q == 3'(DATA_BITS - 1));

    // Frame sequencing: start detect, data capture, parity and stop sampling
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        frame_ok = 1'b0;
        fe_d     = 1'b0;
`ifdef S2P_PARITY_EN
        pe_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en && !a && start_ok) begin
                    state_d = TRANSMIT;
                    cnt_d   = 3'd0;
                end
            end
            TRANSMIT: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (cnt_q == 3'(i)) shift_d[i] = a;
                    end
                    if (last_bit) begin
                        cnt_d   = 3'd0;
`ifdef S2P_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
`ifdef S2P_PARITY_EN
            PARITY: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (^{shift_q, a}) begin
                    pe_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                state_d = IDLE;
                if (en) begin
                    if (a) frame_ok = 1'b1;
                    else   fe_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word hand-off: deliver, hold for ack, or flag overrun
    always_comb begin
        out_d = out_q;
        rdy_d = rdy_q;
        ov_d  = 1'b0;
        if (frame_ok) begin
            if (!rdy_q || ack) begin
                out_d = shift_q;
                rdy_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (ack) begin
            rdy_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            shift_q  <= '0;
            out_q    <= '0;
            rdy_q    <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            prev_a_q <= 1'b1;
`ifdef S2P_PARITY_EN
            pe_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            rdy_q    <= rdy_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            prev_a_q <= a;
`ifdef S2P_PARITY_EN
            pe_q     <= pe_d;
`endif
        end
    end

    assign out_p     = out_q;
    assign ready     = rdy_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = fe_q;
    assign overrun   = ov_q;
`ifdef S2P_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_rx_controller.sv
// Bench for s2p_rx_controller: vector table, directed corner cases,
// random frames against a frame-level reference model.
module tb_s2p_rx_controller;

    logic       clk = 1'b0;
    logic       rst, en, a, ack;
    logic [7:0] out_p;
    logic       ready, busy, frame_err, overrun, parity_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_out;
    logic       m_rdy;

    always #5 clk = ~clk;

    s2p_rx_controller dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .ack        (ack),
        .out_p      (out_p),
        .ready      (ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    typedef struct {
        logic       rst, en, a, ack;
        logic [7:0] eo;
        logic       er, eb, efe, eov, epe;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, e, d, k,
                                input logic [7:0] o,
                                input logic rd, b, f, v, p);
        vec_t t;
        t.rst = r; t.en = e; t.a = d; t.ack = k;
        t.eo = o; t.er = rd; t.eb = b;
        t.efe = f; t.eov = v; t.epe = p;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // flags packed as {busy, frame_err, overrun, parity_err}
    task automatic chk_all(input string nm, input logic fe, ov, pe, bsy);
        chk({nm, ".out_p"}, 32'(out_p), 32'(m_out));
        chk({nm, ".ready"}, 32'(ready), 32'(m_rdy));
        chk({nm, ".flags"},
            32'({busy, frame_err, overrun, parity_err}),
            32'({bsy, fe, ov, pe}));
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop,
                              input logic pbad, input logic ack_stop,
                              input string nm);
        logic ack_eff, acc, fe, ov, pe_e;
        en = 1'b1; ack = 1'b0; a = 1'b0;
        tick;
        chk({nm, ".start_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            a = w[i];
            tick;
            chk({nm, ".data_busy"}, 32'(busy), 32'd1);
        end
`ifdef S2P_PARITY_EN
        pe_e = pbad;
        a = (^w) ^ pbad;
        tick;
        if (pbad) begin
            ack_eff = 1'b0;
        end else begin
            a = stop; ack = ack_stop;
            tick;
            ack_eff = ack_stop;
        end
`else
        pe_e = 1'b0 & pbad;
        a = stop; ack = ack_stop;
        tick;
        ack_eff = ack_stop;
`endif
        acc = !pe_e && stop;
        fe  = !pe_e && !stop;
        ov  = 1'b0;
        if (acc) begin
            if (!m_rdy || ack_eff) begin
                m_out = w;
                m_rdy = 1'b1;
            end else begin
                ov = 1'b1;
            end
        end else if (ack_eff) begin
            m_rdy = 1'b0;
        end
        chk_all(nm, fe, ov, pe_e, 1'b0);
        ack = 1'b0; a = 1'b1;
    endtask

    task automatic idle(input int n, input logic ackv, input string nm);
        for (int k = 0; k < n; k++) begin
            en = 1'b1; a = 1'b1;
            ack = (k == 0) ? ackv : 1'b0;
            tick;
            if (ack) m_rdy = 1'b0;
            chk_all(nm, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ack = 1'b0;
    endtask

    task automatic abort_frame(input logic [7:0] w, input int k,
                               input string nm);
        en = 1'b1; ack = 1'b0; a = 1'b0;
        tick;
        for (int i = 0; i < k; i++) begin
            a = w[i];
            tick;
        end
        en = 1'b0; a = w[k];
        tick;
        chk_all(nm, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; a = 1'b1;
    endtask

    task automatic reset_frame(input logic [7:0] w, input int k,
                               input string nm);
        en = 1'b1; ack = 1'b0; a = 1'b0;
        tick;
        for (int i = 0; i < k; i++) begin
            a = w[i];
            tick;
        end
        rst = 1'b1; a = w[k]; ack = 1'b1;
        tick;
        m_out = 8'h00; m_rdy = 1'b0;
        chk_all(nm, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; ack = 1'b0; a = 1'b1;
    endtask

    initial begin
        logic [7:0] wa5;
        wa5 = 8'hA5;
        rst = 1'b1; en = 1'b0; a = 1'b1; ack = 1'b0;
        m_out = 8'h00; m_rdy = 1'b0;

        vt.push_back(mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(0, 1, wa5[i], 0, 8'h00, 0, 1, 0, 0, 0));
`ifdef S2P_PARITY_EN
        vt.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
`endif
        vt.push_back(mk(0, 1, 1, 0, 8'hA5, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 0, 8'hA5, 0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; en = vt[i].en;
            a = vt[i].a; ack = vt[i].ack;
            tick;
            checks++;
            if ({out_p, ready, busy, frame_err, overrun, parity_err} !==
                {vt[i].eo, vt[i].er, vt[i].eb,
                 vt[i].efe, vt[i].eov, vt[i].epe}) begin
                failures++;
                $display("FAIL vec[%0d] actual=%h/%b%b%b%b%b expected=%h/%b%b%b%b%b",
                         i, out_p, ready, busy, frame_err, overrun, parity_err,
                         vt[i].eo, vt[i].er, vt[i].eb,
                         vt[i].efe, vt[i].eov, vt[i].epe);
            end
        end
        ack = 1'b0;
        m_out = 8'hA5; m_rdy = 1'b0;

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "ferr");
        a = 1'b0;
        tick;
        chk_all("idle_low1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        chk_all("idle_low2", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, "ferr_idle");

        send_frame(8'h11, 1'b1, 1'b0, 1'b0, "w11");
        idle(1, 1'b0, "w11_idle");
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, "ovr");
        idle(1, 1'b0, "ovr_idle");
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, "ack_same");
        idle(2, 1'b1, "ack_idle");

        abort_frame(8'hFF, 3, "abort");
        idle(1, 1'b0, "abort_idle");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, "after_abort");
        idle(1, 1'b0, "aa_idle");

        reset_frame(8'h00, 4, "midreset");
        idle(1, 1'b0, "rst_idle");
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, "after_reset");
        idle(1, 1'b1, "ar_idle");

`ifdef S2P_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, "par_ok");
        idle(1, 1'b1, "po_idle");
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, "par_bad");
        idle(1, 1'b0, "pb_idle");
`endif

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [7:0] w;
            r = $urandom_range(0, 9);
            w = 8'($urandom);
            if (r == 0)
                abort_frame(w, $urandom_range(0, 7), "rnd_abort");
            else if (r == 1)
                reset_frame(w, $urandom_range(0, 7), "rnd_reset");
            else
                send_frame(w, 1'($urandom_range(0, 5) != 0),
                           1'($urandom_range(0, 4) == 0),
                           1'($urandom_range(0, 1)), "rnd_frame");
            idle($urandom_range(1, 3), 1'($urandom_range(0, 3) == 0),
                 "rnd_idle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
